// File: rtl/dmem_byte_store.sv
// Byte-addressed little-endian data memory for the MEM stage: combinational word reads, synchronous word writes.
// Optional macro DMEM_INIT_EN marks every byte valid on reset.
module dmem_byte_store #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_WIDTH      = 32,
    parameter int ADDRESS_REAL_WIDTH = 12,
    parameter     INIT_FILE          = "data.hex"
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WDME,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    output logic [DATA_WIDTH-1:0]    RD
);

    localparam int DEPTH  = 2 ** ADDRESS_REAL_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [7:0]                    r_mem [DEPTH];
    logic [DEPTH-1:0]              r_vld;
    logic [ADDRESS_REAL_WIDTH-1:0] w_addr;
    logic [ADDRESS_REAL_WIDTH-1:0] w_lane [NBYTES];
    logic                          w_wr_en;
    logic                          w_unused_addr;

    // Upper address bits alias onto the implemented range.
    assign w_addr        = A[ADDRESS_REAL_WIDTH-1:0];
    assign w_unused_addr = ^A[ADDRESS_WIDTH-1:ADDRESS_REAL_WIDTH];
    // An X enable compares as unknown and therefore never writes.
    assign w_wr_en       = (WDME == 1'b1);

    // Byte lanes wrap modulo the depth through the natural overflow of the add.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        assign w_lane[g] = w_addr + ADDRESS_REAL_WIDTH'(g);
    end

    // Byte storage: written per lane at the clock edge only when out of reset.
    always_ff @(posedge clk) begin
        if (rst == 1'b1 && w_wr_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                r_mem[w_lane[k]] <= WD[8*k +: 8];
            end
        end
    end

    // Per-byte valid bits: cleared (or set, when preloaded) asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef DMEM_INIT_EN
            r_vld <= {DEPTH{1'b1}};
`else
            r_vld <= {DEPTH{1'b0}};
`endif
        end else if (w_wr_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                r_vld[w_lane[k]] <= 1'b1;
            end
        end else begin
            r_vld <= r_vld;
        end
    end

    // Combinational load path; bytes never written read as zero.
    always_comb begin
        RD = {DATA_WIDTH{1'b0}};
        if (rst == 1'b1) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_vld[w_lane[k]]) begin
                    RD[8*k +: 8] = r_mem[w_lane[k]];
                end else begin
                    RD[8*k +: 8] = 8'h00;
                end
            end
        end else begin
            RD = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_dmem_byte_store.sv
// Directed bench for dmem_byte_store (default build, DMEM_INIT_EN undefined).
module tb_dmem_byte_store;

    logic        clk;
    logic        rst;
    logic        WDME;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;

    int n_cmp;
    int n_err;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs [11];

    dmem_byte_store dut (
        .clk  (clk),
        .rst  (rst),
        .WDME (WDME),
        .A    (A),
        .WD   (WD),
        .RD   (RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        WDME = 1'b1;
        A    = addr;
        WD   = data;
        @(posedge clk);
        #1;
        @(negedge clk);
        WDME = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        A = addr;
        #1;
        check(name, RD, exp);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        WDME  = 1'b0;
        A     = 32'h0;
        WD    = 32'h0;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, "wr_100"};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, "rd_aligned"};
        vecs[2]  = '{1'b0, 32'h0000_0101, 32'h00DE_ADBE, "rd_misaligned_101"};
        vecs[3]  = '{1'b0, 32'h0000_00FF, 32'hADBE_EF00, "rd_misaligned_0ff"};
        vecs[4]  = '{1'b1, 32'h0000_0FFE, 32'h1122_3344, "wr_ffe"};
        vecs[5]  = '{1'b0, 32'h0000_0FFE, 32'h1122_3344, "rd_wrap_ffe"};
        vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_1122, "rd_wrap_0"};
        vecs[7]  = '{1'b0, 32'h1000_0FFE, 32'h1122_3344, "rd_alias"};
        vecs[8]  = '{1'b1, 32'h0000_0102, 32'hCAFE_F00D, "wr_overlap_102"};
        vecs[9]  = '{1'b0, 32'h0000_0100, 32'hF00D_BEEF, "rd_overlap_100"};
        vecs[10] = '{1'b0, 32'h0000_0104, 32'h0000_CAFE, "rd_overlap_104"};

        #2;
        check("rd_in_reset", RD, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h0,  32'h0, "rd_after_reset_0");
        do_read(32'h10, 32'h0, "rd_after_reset_10");

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data);
            end else begin
                do_read(vecs[i].addr, vecs[i].data, vecs[i].name);
            end
        end

        // WDME low for several edges leaves the word untouched.
        @(negedge clk);
        WDME = 1'b0;
        A    = 32'h100;
        WD   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("write_blocked", RD, 32'hF00D_BEEF);

        // An unknown enable must not write.
        @(negedge clk);
        WDME = 1'bx;
        A    = 32'h200;
        WD   = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        WDME = 1'b0;
        check("wdme_x_no_write", RD, 32'h0);

        // Read-during-write: old data before the edge, new data after it.
        @(negedge clk);
        WDME = 1'b1;
        A    = 32'h100;
        WD   = 32'h1234_5678;
        #1;
        check("rdw_before_edge", RD, 32'hF00D_BEEF);
        @(posedge clk);
        #1;
        check("rdw_after_edge", RD, 32'h1234_5678);
        @(negedge clk);
        WDME = 1'b0;

        // Reset between edges clears reads at once and blocks writes.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rd_async_reset", RD, 32'h0);
        WDME = 1'b1;
        A    = 32'h300;
        WD   = 32'hA5A5_A5A5;
        @(posedge clk);
        #1;
        check("rd_during_reset", RD, 32'h0);
        @(negedge clk);
        WDME = 1'b0;
        rst  = 1'b1;
        #1;
        check("no_write_in_reset", RD, 32'h0);
        do_read(32'h100, 32'h0, "rd_100_after_reset");
        do_read(32'hFFE, 32'h0, "rd_ffe_after_reset");

        do_write(32'h300, 32'h0BAD_F00D);
        do_read(32'h300, 32'h0BAD_F00D, "wr_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
